// File: rtl/sram_req_tracker.sv
// Outstanding-request tracker between a pipeline port and an in-order sram-like bus.
// Keeps a circular FIFO of {tag, discard} per in-flight request and suppresses flushed responses.
module sram_req_tracker #(
  parameter int DEPTH        = 2,
  parameter int TAG_W        = 4,
  parameter int BLOCK_ON_DIS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     up_req,
  input  logic                     up_wr,
  input  logic [1:0]               up_size,
  input  logic [31:0]              up_addr,
  input  logic [3:0]               up_wstrb,
  input  logic [31:0]              up_wdata,
  input  logic [TAG_W-1:0]         up_tag,
  output logic                     up_addr_ok,
  output logic                     up_data_ok,
  output logic [31:0]              up_rdata,
  output logic [TAG_W-1:0]         up_rtag,
  output logic                     dn_req,
  output logic                     dn_wr,
  output logic [1:0]               dn_size,
  output logic [31:0]              dn_addr,
  output logic [3:0]               dn_wstrb,
  output logic [31:0]              dn_wdata,
  input  logic                     dn_addr_ok,
  input  logic                     dn_data_ok,
  input  logic [31:0]              dn_rdata,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     discard_pend,
  output logic                     proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a request transfers on the cycle dn_req & dn_addr_ok are both high
  // (reported upstream as up_addr_ok); a response transfers on dn_data_ok and is
  // matched to the oldest in-flight entry, forwarded as up_data_ok unless discarded.

  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] dis_q, dis_d;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             proto_err_q;

  logic full, empty, block, accept, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign discard_pend = |(vld_q & dis_q);
  assign block = (BLOCK_ON_DIS != 0) && discard_pend;

  // Gating with reset keeps the bus quiet while state is being cleared.
  assign dn_req     = ~reset & up_req & ~full & ~flush & ~block;
  assign accept     = dn_req & dn_addr_ok;
  assign pop        = ~reset & dn_data_ok & ~empty;
  assign up_addr_ok = accept;
  assign up_data_ok = pop & ~dis_q[rptr_q] & ~flush;
  assign up_rtag    = tag_q[rptr_q];
  assign up_rdata   = dn_rdata;

  assign dn_wr    = up_wr;
  assign dn_size  = up_size;
  assign dn_addr  = up_addr;
  assign dn_wstrb = up_wstrb;
  assign dn_wdata = up_wdata;

  assign outstanding = count_q;
  assign proto_err   = proto_err_q;

  // Flush marks first; a pop or accept on the same cycle then overrides its own slot.
  // Pop and accept never share a slot: equal pointers mean empty (no pop) or full (no accept).
  always_comb begin
    vld_d = vld_q;
    dis_d = dis_q;
    if (flush) dis_d = dis_q | vld_q;
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      dis_d[rptr_q] = 1'b0;
    end
    if (accept) begin
      vld_d[wptr_q] = 1'b1;
      dis_d[wptr_q] = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= '0;
      dis_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      dis_q   <= dis_d;
      count_q <= count_d;
      if (accept) wptr_q <= wptr_q + 1'b1;
      if (pop)    rptr_q <= rptr_q + 1'b1;
      if (dn_data_ok && empty) proto_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_q[wptr_q] <= up_tag;
  end

endmodule

// File: tb/tb_sram_req_tracker.sv
// Directed bench for sram_req_tracker: responses checked by a queue-driven monitor,
// control/status outputs checked inline with hand-computed values.
module tb_sram_req_tracker;

  logic        clk, reset, flush;
  logic        up_req, up_wr;
  logic [1:0]  up_size;
  logic [31:0] up_addr, up_wdata;
  logic [3:0]  up_wstrb, up_tag;
  logic        up_addr_ok, up_data_ok;
  logic [31:0] up_rdata;
  logic [3:0]  up_rtag;
  logic        dn_req, dn_wr;
  logic [1:0]  dn_size;
  logic [31:0] dn_addr, dn_wdata;
  logic [3:0]  dn_wstrb;
  logic        dn_addr_ok, dn_data_ok;
  logic [31:0] dn_rdata;
  logic [1:0]  outstanding;
  logic        discard_pend, proto_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [35:0] exp_q[$];

  sram_req_tracker #(.DEPTH(2), .TAG_W(4), .BLOCK_ON_DIS(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .up_req(up_req), .up_wr(up_wr), .up_size(up_size), .up_addr(up_addr),
    .up_wstrb(up_wstrb), .up_wdata(up_wdata), .up_tag(up_tag),
    .up_addr_ok(up_addr_ok), .up_data_ok(up_data_ok), .up_rdata(up_rdata), .up_rtag(up_rtag),
    .dn_req(dn_req), .dn_wr(dn_wr), .dn_size(dn_size), .dn_addr(dn_addr),
    .dn_wstrb(dn_wstrb), .dn_wdata(dn_wdata),
    .dn_addr_ok(dn_addr_ok), .dn_data_ok(dn_data_ok), .dn_rdata(dn_rdata),
    .outstanding(outstanding), .discard_pend(discard_pend), .proto_err(proto_err)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive(input logic req, input logic [3:0] tag, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic fl);
    up_req     = req;
    up_tag     = tag;
    up_addr    = 32'h1000_0000 + {28'h0, tag};
    dn_addr_ok = aok;
    dn_data_ok = dok;
    dn_rdata   = rd;
    flush      = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [3:0] tag, input logic [31:0] data);
    exp_q.push_back({tag, data});
  endtask

  // scoreboard monitor: every up_data_ok must match the oldest expected response
  always @(negedge clk) begin
    if (up_data_ok) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_data_ok: got rtag %0h rdata %0h expected no response", up_rtag, up_rdata);
      end else begin
        check("response", {up_rtag, up_rdata}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; up_wr = 1'b0; up_size = 2'd2; up_wstrb = 4'hf; up_wdata = 32'h0;
    drive(1'b1, 4'h0, 1'b1, 1'b1, 32'h0, 1'b0);
    #1;
    @(negedge clk);
    check("reset_dn_req", {35'h0, dn_req}, 36'h0);
    check("reset_addr_ok", {35'h0, up_addr_ok}, 36'h0);
    check("reset_outstanding", {34'h0, outstanding}, 36'h0);
    check("reset_discard_pend", {35'h0, discard_pend}, 36'h0);
    check("reset_proto_err", {35'h0, proto_err}, 36'h0);
    next_cyc();
    reset = 1'b0;
    idle();
    next_cyc();

    // 1: single read
    drive(1'b1, 4'h3, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t1_addr_ok", {35'h0, up_addr_ok}, 36'h1);
    check("t1_dn_addr", {4'h0, dn_addr}, 36'h0_1000_0003);
    next_cyc();
    idle();
    @(negedge clk);
    check("t1_outst_c1", {34'h0, outstanding}, 36'h1);
    next_cyc();
    expect_rsp(4'h3, 32'hDEAD_BEEF);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("t1_outst_c2", {34'h0, outstanding}, 36'h1);
    next_cyc();
    idle();
    @(negedge clk);
    check("t1_outst_c3", {34'h0, outstanding}, 36'h0);
    check("t1_drained", exp_q.size(), 36'h0);
    next_cyc();

    // 2: full throttling
    drive(1'b1, 4'h1, 1'b1, 1'b0, 32'h0, 1'b0);
    next_cyc();
    drive(1'b1, 4'h2, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t2_second_accept", {35'h0, up_addr_ok}, 36'h1);
    next_cyc();
    drive(1'b1, 4'h5, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t2_full_dn_req", {35'h0, dn_req}, 36'h0);
    check("t2_full_outst", {34'h0, outstanding}, 36'h2);
    next_cyc();
    expect_rsp(4'h1, 32'h0000_0011);
    drive(1'b1, 4'h5, 1'b1, 1'b1, 32'h0000_0011, 1'b0);
    @(negedge clk);
    check("t2_full_pop_no_accept", {35'h0, up_addr_ok}, 36'h0);
    next_cyc();
    drive(1'b1, 4'h5, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t2_reopen_accept", {35'h0, up_addr_ok}, 36'h1);
    next_cyc();
    expect_rsp(4'h2, 32'h0000_0022);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0000_0022, 1'b0);
    next_cyc();
    expect_rsp(4'h5, 32'h0000_0055);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0000_0055, 1'b0);
    next_cyc();
    idle();
    @(negedge clk);
    check("t2_outst_end", {34'h0, outstanding}, 36'h0);
    check("t2_drained", exp_q.size(), 36'h0);
    next_cyc();

    // 3: flush with two in flight
    drive(1'b1, 4'h6, 1'b1, 1'b0, 32'h0, 1'b0);
    next_cyc();
    drive(1'b1, 4'h7, 1'b1, 1'b0, 32'h0, 1'b0);
    next_cyc();
    drive(1'b1, 4'h8, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("t3_flush_dn_req", {35'h0, dn_req}, 36'h0);
    next_cyc();
    drive(1'b1, 4'h8, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t3_discard_pend", {35'h0, discard_pend}, 36'h1);
    check("t3_blocked", {35'h0, dn_req}, 36'h0);
    next_cyc();
    drive(1'b1, 4'h8, 1'b1, 1'b1, 32'h0000_0066, 1'b0);
    @(negedge clk);
    check("t3_pop1_suppressed", {35'h0, up_data_ok}, 36'h0);
    next_cyc();
    drive(1'b1, 4'h8, 1'b1, 1'b1, 32'h0000_0077, 1'b0);
    @(negedge clk);
    check("t3_pop2_blocked", {35'h0, up_addr_ok}, 36'h0);
    next_cyc();
    drive(1'b1, 4'h8, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t3_pend_clear", {35'h0, discard_pend}, 36'h0);
    check("t3_accept_after", {35'h0, up_addr_ok}, 36'h1);
    next_cyc();
    expect_rsp(4'h8, 32'h0000_0088);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0000_0088, 1'b0);
    next_cyc();
    idle();
    @(negedge clk);
    check("t3_drained", exp_q.size(), 36'h0);
    next_cyc();

    // 4: flush coincident with pop and request
    drive(1'b1, 4'h9, 1'b1, 1'b0, 32'h0, 1'b0);
    next_cyc();
    drive(1'b1, 4'ha, 1'b1, 1'b0, 32'h0, 1'b0);
    next_cyc();
    drive(1'b1, 4'hb, 1'b1, 1'b1, 32'h0000_0099, 1'b1);
    @(negedge clk);
    check("t4_data_ok_masked", {35'h0, up_data_ok}, 36'h0);
    check("t4_addr_ok_masked", {35'h0, up_addr_ok}, 36'h0);
    next_cyc();
    idle();
    @(negedge clk);
    check("t4_outst", {34'h0, outstanding}, 36'h1);
    check("t4_pend", {35'h0, discard_pend}, 36'h1);
    next_cyc();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0000_00AA, 1'b0);
    @(negedge clk);
    check("t4_remaining_suppressed", {35'h0, up_data_ok}, 36'h0);
    next_cyc();
    idle();
    @(negedge clk);
    check("t4_outst_end", {34'h0, outstanding}, 36'h0);
    check("t4_pend_end", {35'h0, discard_pend}, 36'h0);
    next_cyc();

    // 5: simultaneous accept+pop at outstanding=1, pointer wrap
    drive(1'b1, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    next_cyc();
    for (int i = 0; i < 5; i++) begin
      expect_rsp(4'(i), 32'hC0DE_0000 + 32'(i));
      drive(1'b1, 4'(i + 1), 1'b1, 1'b1, 32'hC0DE_0000 + 32'(i), 1'b0);
      @(negedge clk);
      check("t5_accept", {35'h0, up_addr_ok}, 36'h1);
      next_cyc();
      idle();
      @(negedge clk);
      check("t5_outst", {34'h0, outstanding}, 36'h1);
      next_cyc();
    end
    expect_rsp(4'h5, 32'hC0DE_0005);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'hC0DE_0005, 1'b0);
    next_cyc();
    idle();
    @(negedge clk);
    check("t5_outst_end", {34'h0, outstanding}, 36'h0);
    check("t5_drained", exp_q.size(), 36'h0);
    next_cyc();

    // 6: reset mid-operation, then response with empty FIFO
    drive(1'b1, 4'h4, 1'b1, 1'b0, 32'h0, 1'b0);
    next_cyc();
    idle();
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    check("t6_midreset_outst", {34'h0, outstanding}, 36'h0);
    next_cyc();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0000_0044, 1'b0);
    @(negedge clk);
    check("t6_empty_no_data_ok", {35'h0, up_data_ok}, 36'h0);
    next_cyc();
    idle();
    @(negedge clk);
    check("t6_proto_err_set", {35'h0, proto_err}, 36'h1);
    check("t6_outst_zero", {34'h0, outstanding}, 36'h0);
    next_cyc();
    @(negedge clk);
    check("t6_proto_err_held", {35'h0, proto_err}, 36'h1);
    next_cyc();
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    check("t6_proto_err_cleared", {35'h0, proto_err}, 36'h0);
    check("t6_outst_after_reset", {34'h0, outstanding}, 36'h0);
    next_cyc();

    check("final_queue_empty", exp_q.size(), 36'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
